// File: rtl/reaction_timer_ctrl_pkg.sv
// ----------------------------------------------------------------------------
// reaction_pkg
// Shared types and constants for the reaction-timer controller slice.
//   TIME_W     : width of every millisecond counter / result (14 bits)
//   LFSR_SEED  : reset value of the foreperiod LFSR (never all-zero)
//   LFSR_TAPS  : feedback mask for x^16+x^14+x^13+x^11+1 (bits 15,13,12,10)
//   state_t    : controller state encoding, also exported on state_o
// ----------------------------------------------------------------------------
package reaction_pkg;

  localparam int TIME_W = 14;

  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_WAIT_RAND = 3'd1,
    ST_ARMED     = 3'd2,
    ST_DONE      = 3'd3,
    ST_EARLY     = 3'd4,
    ST_TIMEOUT   = 3'd5
  } state_t;

endpackage

// File: rtl/reaction_timer_ctrl_if.sv
// ----------------------------------------------------------------------------
// reaction_timer_ctrl_if
// Bundles the debounced button ticks and the result/status outputs of the
// reaction-timer controller.
//   master : drives start/stop/clear ticks, observes results (debouncer side)
//   slave  : the controller itself
// Signals:
//   start_tick_i, stop_tick_i, clear_tick_i : single-cycle debounced pulses
//   led_o       : stimulus LED
//   time_ms_o   : measured / elapsed reaction time (ms)
//   delay_ms_o  : foreperiod latched for the current trial (ms)
//   state_o     : encoded controller state
//   done_o, early_o, timeout_o : outcome flags
//   best_ms_o   : best reaction time, only with REACTION_BEST_TIME_EN
// ----------------------------------------------------------------------------
interface reaction_timer_ctrl_if;
  import reaction_pkg::*;

  logic              start_tick_i;
  logic              stop_tick_i;
  logic              clear_tick_i;
  logic              led_o;
  logic [TIME_W-1:0] time_ms_o;
  logic [TIME_W-1:0] delay_ms_o;
  logic [2:0]        state_o;
  logic              done_o;
  logic              early_o;
  logic              timeout_o;
`ifdef REACTION_BEST_TIME_EN
  logic [TIME_W-1:0] best_ms_o;
`endif

  modport master (
    output start_tick_i, stop_tick_i, clear_tick_i,
    input  led_o, time_ms_o, delay_ms_o, state_o, done_o, early_o, timeout_o
`ifdef REACTION_BEST_TIME_EN
    , input best_ms_o
`endif
  );

  modport slave (
    input  start_tick_i, stop_tick_i, clear_tick_i,
    output led_o, time_ms_o, delay_ms_o, state_o, done_o, early_o, timeout_o
`ifdef REACTION_BEST_TIME_EN
    , output best_ms_o
`endif
  );

endinterface

// File: rtl/reaction_timer_ctrl_lfsr16.sv
// ----------------------------------------------------------------------------
// lfsr16
// Free-running 16-bit Fibonacci LFSR (x^16+x^14+x^13+x^11+1). Advances on
// every clock; the maximal-length polynomial keeps it out of the all-zero
// lock-up state as long as SEED is nonzero.
// Ports:
//   clk_i    : clock
//   reset_ni : asynchronous active-low reset, loads SEED
//   lfsr_o   : current LFSR value
// ----------------------------------------------------------------------------
module lfsr16
  import reaction_pkg::*;
#(
  parameter logic [15:0] SEED = LFSR_SEED
) (
  input  logic        clk_i,
  input  logic        reset_ni,
  output logic [15:0] lfsr_o
);

  logic [15:0] lfsr_q;

  if (SEED == 16'h0000) begin : g_bad_seed
    $error("lfsr16: SEED must be nonzero");
  end

  // Shift left, feeding back the XOR of the tapped bits into bit 0.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      lfsr_q <= SEED;
    end else begin
      lfsr_q <= {lfsr_q[14:0], ^(lfsr_q & LFSR_TAPS)};
    end
  end

  assign lfsr_o = lfsr_q;

endmodule

// File: rtl/reaction_timer_ctrl.sv
// ----------------------------------------------------------------------------
// reaction_timer_ctrl
// Reaction-timer game sequencer. On a start tick it latches a pseudo-random
// foreperiod, waits that many milliseconds, lights the LED and then measures
// the time to the stop tick. Early and timeout outcomes are flagged and held
// until a clear tick. All outputs are registered.
// Optional feature macro: REACTION_BEST_TIME_EN adds best_ms_o, the lowest
// DONE time since reset (14'h3FFF = no record).
// Ports:
//   clk_i    : clock
//   reset_ni : asynchronous active-low reset
//   bus      : reaction_timer_ctrl_if.slave (ticks in, results out)
// ----------------------------------------------------------------------------
module reaction_timer_ctrl
  import reaction_pkg::*;
#(
  parameter int TICKS_PER_MS = 100000,
  parameter int MIN_DELAY_MS = 2000,
  parameter int RAND_BITS    = 12,
  parameter int TIMEOUT_MS   = 1000
) (
  input  logic                 clk_i,
  input  logic                 reset_ni,
  reaction_timer_ctrl_if.slave bus
);

  localparam int PRE_W = (TICKS_PER_MS > 1) ? $clog2(TICKS_PER_MS) : 1;
  localparam logic [PRE_W-1:0]  PRE_LAST     = PRE_W'(TICKS_PER_MS - 1);
  localparam logic [TIME_W-1:0] MIN_DELAY    = TIME_W'(MIN_DELAY_MS);
  localparam logic [TIME_W-1:0] TIMEOUT_LAST = TIME_W'(TIMEOUT_MS - 1);
  localparam logic [TIME_W-1:0] TIMEOUT_VAL  = TIME_W'(TIMEOUT_MS);

  if (TICKS_PER_MS < 1) begin : g_bad_ticks
    $error("reaction_timer_ctrl: TICKS_PER_MS must be at least 1");
  end
  if (TIMEOUT_MS < 1 || TIMEOUT_MS > 9999) begin : g_bad_timeout
    $error("reaction_timer_ctrl: TIMEOUT_MS must be within 1..9999");
  end
  if (RAND_BITS < 1 || RAND_BITS >= TIME_W || MIN_DELAY_MS < 1 ||
      MIN_DELAY_MS + (1 << RAND_BITS) - 1 > 16383) begin : g_bad_delay
    $error("reaction_timer_ctrl: foreperiod range does not fit 14 bits");
  end

  logic [15:0]       lfsr;
  logic [TIME_W-1:0] rand_ms;
  logic              unused_lfsr_bits;

  state_t            state_q, state_d;
  logic [PRE_W-1:0]  presc_q;
  logic              presc_clr;
  logic              ms_strobe;
  logic [TIME_W-1:0] ms_cnt_q, ms_cnt_d;
  logic [TIME_W-1:0] time_q, time_d;
  logic [TIME_W-1:0] delay_q, delay_d;
  logic              led_q, led_d;
  logic              done_q, done_d;
  logic              early_q, early_d;
  logic              timeout_q, timeout_d;
`ifdef REACTION_BEST_TIME_EN
  logic [TIME_W-1:0] best_q, best_d;
`endif

  lfsr16 #(.SEED(LFSR_SEED)) u_lfsr (
    .clk_i    (clk_i),
    .reset_ni (reset_ni),
    .lfsr_o   (lfsr)
  );

  // Only the low RAND_BITS of the LFSR set the random part of the foreperiod.
  assign rand_ms          = TIME_W'(lfsr[RAND_BITS-1:0]);
  assign unused_lfsr_bits = ^lfsr[15:RAND_BITS];

  assign ms_strobe = (presc_q == PRE_LAST);

  // Millisecond prescaler. It free-runs, but is restarted whenever a timed
  // phase begins so the first millisecond of that phase is a full one.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      presc_q <= '0;
    end else if (presc_clr || ms_strobe) begin
      presc_q <= '0;
    end else begin
      presc_q <= presc_q + PRE_W'(1);
    end
  end

  // Controller register bank: state plus every registered output.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q   <= ST_IDLE;
      ms_cnt_q  <= '0;
      time_q    <= '0;
      delay_q   <= '0;
      led_q     <= 1'b0;
      done_q    <= 1'b0;
      early_q   <= 1'b0;
      timeout_q <= 1'b0;
`ifdef REACTION_BEST_TIME_EN
      best_q    <= '1;
`endif
    end else begin
      state_q   <= state_d;
      ms_cnt_q  <= ms_cnt_d;
      time_q    <= time_d;
      delay_q   <= delay_d;
      led_q     <= led_d;
      done_q    <= done_d;
      early_q   <= early_d;
      timeout_q <= timeout_d;
`ifdef REACTION_BEST_TIME_EN
      best_q    <= best_d;
`endif
    end
  end

  // Next-state and next-output logic. Clear wins over everything, then stop,
  // then start. A stop in ARMED freezes the time even on a strobe cycle, so
  // the recorded value is the one shown before that edge.
  always_comb begin
    state_d   = state_q;
    ms_cnt_d  = ms_cnt_q;
    time_d    = time_q;
    delay_d   = delay_q;
    led_d     = led_q;
    done_d    = done_q;
    early_d   = early_q;
    timeout_d = timeout_q;
    presc_clr = 1'b0;
`ifdef REACTION_BEST_TIME_EN
    best_d    = best_q;
`endif

    if (bus.clear_tick_i) begin
      state_d   = ST_IDLE;
      ms_cnt_d  = '0;
      time_d    = '0;
      delay_d   = '0;
      led_d     = 1'b0;
      done_d    = 1'b0;
      early_d   = 1'b0;
      timeout_d = 1'b0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          led_d  = 1'b0;
          time_d = '0;
          if (bus.start_tick_i) begin
            state_d   = ST_WAIT_RAND;
            delay_d   = MIN_DELAY + rand_ms;
            ms_cnt_d  = '0;
            presc_clr = 1'b1;
          end
        end
        ST_WAIT_RAND: begin
          if (bus.stop_tick_i) begin
            state_d = ST_EARLY;
            early_d = 1'b1;
            led_d   = 1'b0;
          end else if (ms_strobe) begin
            if (ms_cnt_q == delay_q - TIME_W'(1)) begin
              state_d   = ST_ARMED;
              led_d     = 1'b1;
              time_d    = '0;
              presc_clr = 1'b1;
            end else begin
              ms_cnt_d = ms_cnt_q + TIME_W'(1);
            end
          end
        end
        ST_ARMED: begin
          if (bus.stop_tick_i) begin
            state_d = ST_DONE;
            done_d  = 1'b1;
            led_d   = 1'b0;
`ifdef REACTION_BEST_TIME_EN
            if (time_q < best_q) begin
              best_d = time_q;
            end
`endif
          end else if (ms_strobe) begin
            if (time_q == TIMEOUT_LAST) begin
              state_d   = ST_TIMEOUT;
              timeout_d = 1'b1;
              led_d     = 1'b0;
              time_d    = TIMEOUT_VAL;
            end else begin
              time_d = time_q + TIME_W'(1);
            end
          end
        end
        ST_DONE, ST_EARLY, ST_TIMEOUT: begin
          led_d = 1'b0;
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  assign bus.led_o      = led_q;
  assign bus.time_ms_o  = time_q;
  assign bus.delay_ms_o = delay_q;
  assign bus.state_o    = state_q;
  assign bus.done_o     = done_q;
  assign bus.early_o    = early_q;
  assign bus.timeout_o  = timeout_q;
`ifdef REACTION_BEST_TIME_EN
  assign bus.best_ms_o  = best_q;
`endif

endmodule

// File: doc/reaction_timer_ctrl.md
Name: reaction_timer_ctrl

Overview:
- Sequencer for the reaction-timer game.
- Consumes single-cycle debounced ticks (start, stop, clear) from the team's button pulse debouncers.
- Generates a pseudo-random foreperiod, drives the stimulus LED, measures reaction time in milliseconds and flags early/timeout outcomes.
- Sits between the debouncers and the display/BCD path.

Parameters:
- TICKS_PER_MS, 100000, clk cycles per millisecond (prescaler terminal count).
- MIN_DELAY_MS, 2000, minimum foreperiod in ms.
- RAND_BITS, 12, LSBs of the LFSR added to MIN_DELAY_MS (span 0..2^RAND_BITS-1 ms).
- TIMEOUT_MS, 1000, reaction limit in ms; must be ≤ 9999.

Ports:
- clk_i  in  1  system clock.
- reset_ni  in  1  asynchronous active-low reset.
- start_tick_i  in  1  debounced start pulse.
- stop_tick_i  in  1  debounced reaction pulse.
- clear_tick_i  in  1  debounced clear pulse.
- led_o  out  1  stimulus LED.
- time_ms_o  out  14  measured/elapsed reaction time, binary.
- delay_ms_o  out  14  latched foreperiod for the current trial.
- state_o  out  3  encoded controller state.
- done_o  out  1  valid result held.
- early_o  out  1  stop arrived before LED.
- timeout_o  out  1  TIMEOUT_MS reached without stop.

Behaviour:
- One clock; reset is asynchronous and active-low.
- Reset: state IDLE; all outputs 0; prescaler 0; LFSR = 16'hACE1.
- All outputs are registered; an input tick at cycle N is reflected on outputs at N+1.
- LFSR: 16-bit Fibonacci, taps x^16+x^14+x^13+x^11+1, advances every cycle in every state, never all-zero.
- Prescaler:
  - Counts 0..TICKS_PER_MS-1.
  - ms_strobe is asserted internally when count == TICKS_PER_MS-1.
  - Cleared on entry to WAIT_RAND and to ARMED.
- Tick priority per cycle: clear > stop > start.
- IDLE:
  - led_o=0, time_ms_o=0.
  - start_tick → WAIT_RAND; delay_ms_o <= MIN_DELAY_MS + lfsr[RAND_BITS-1:0]; internal ms counter <= 0.
  - stop is ignored.
- WAIT_RAND:
  - ms counter increments on ms_strobe.
  - stop_tick → EARLY.
  - On ms_strobe with counter == delay_ms_o-1 → ARMED; led_o=1; time_ms_o <= 0.
  - Stop on the same cycle as the terminal strobe → EARLY.
- ARMED:
  - time_ms_o increments on ms_strobe.
  - stop_tick → DONE; time_ms_o holds the current value, with no increment that cycle even if ms_strobe is asserted.
  - On ms_strobe with time_ms_o == TIMEOUT_MS-1 → TIMEOUT; time_ms_o = TIMEOUT_MS.
- DONE / EARLY / TIMEOUT:
  - led_o=0; the corresponding flag is held at 1 and time_ms_o is held.
  - start_tick and stop_tick are ignored.
  - clear_tick → IDLE; flags, time_ms_o and delay_ms_o are zeroed.
- clear_tick in any state → IDLE next cycle.
- Reset mid-trial returns to IDLE immediately, asynchronously.
- state_o encoding: IDLE=0, WAIT_RAND=1, ARMED=2, DONE=3, EARLY=4, TIMEOUT=5.
- Width rules: counters are 14-bit unsigned; the delay sum is computed at 14 bits; the parameter check requires MIN_DELAY_MS + 2^RAND_BITS - 1 ≤ 16383.

Optional Feature:
- Macro REACTION_BEST_TIME_EN.
- When defined:
  - Adds output best_ms_o [13:0], reset to 14'h3FFF (no record).
  - On entry to DONE, best_ms_o <= min(best_ms_o, time_ms_o).
  - EARLY/TIMEOUT never update it; clear_tick does not reset it, only reset_ni does.
- When undefined: port and register are absent; behaviour is otherwise identical.

Decomposition:
- Package reaction_pkg holds:
  - state enum typedef (3-bit);
  - LFSR seed and tap constants;
  - TIME_W = 14.
- Sub-module lfsr16, a free-running LFSR with seed parameter, output 16-bit.
- The prescaler and FSM stay in the top module.

Test Plan:
- All scenarios use TICKS_PER_MS=4, MIN_DELAY_MS=3, RAND_BITS=2, TIMEOUT_MS=10.
- Normal trial: start → delay_ms_o ∈ 3..6; LED rises 4×delay_ms_o cycles after start+1; stop 22 cycles after LED → DONE, time_ms_o=5, done_o=1.
- Early: start, stop 2 cycles later → state_o=4, early_o=1, led_o=0, time_ms_o=0.
- Timeout: start, wait for LED, no stop → 40 cycles after LED rises, state_o=5, timeout_o=1, time_ms_o=10.
- Priority and ignored ticks:
  - clear+stop in the same cycle during ARMED → IDLE, all flags 0.
  - start in DONE → ignored, time_ms_o unchanged.
- Boundaries:
  - stop on the same cycle as a ms_strobe in ARMED → recorded time equals the pre-increment value.
  - reset_ni pulsed low mid-WAIT_RAND → outputs 0 asynchronously, LFSR=16'hACE1.
- With REACTION_BEST_TIME_EN:
  - trials of 5 ms then 3 ms then 7 ms → best_ms_o 5, 3, 3.
  - an EARLY trial leaves it unchanged.
